// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter for a single 1-cycle-latency byte RAM port, with bounded bursts and tagged read return.
// Optional ARB_STATS_EN adds per-requester beat/wait counters (saturating, clearable by stat_clr).
module mem_port_arbiter #(
  parameter int AW        = 16,
  parameter int DW        = 8,
  parameter int MAX_BURST = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_gnt,
  output logic          r0_rvalid,
  output logic [DW-1:0] r0_rdata,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_gnt,
  output logic          r1_rvalid,
  output logic [DW-1:0] r1_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
`ifdef ARB_STATS_EN
  input  logic          stat_clr,
  output logic [15:0]   stat_beats0,
  output logic [15:0]   stat_beats1,
  output logic [15:0]   stat_wait0,
  output logic [15:0]   stat_wait1,
`endif
  output logic          owner
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST - 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] burst_cnt_q, burst_cnt_d, cnt_cur;
  logic          last_q, last_d;
  logic          owner_q;
  logic          rd_pend_q, rd_pend_d;
  logic          rd_tag_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic          grant, sel, fresh, other_req, we_sel;

  always_comb begin
    grant = 1'b0;
    sel   = owner_q;
    fresh = 1'b0;
    case (state_q)
      IDLE: begin
        if (r0_req && r1_req) begin
          grant = 1'b1; sel = ~last_q; fresh = 1'b1;
        end else if (r0_req) begin
          grant = 1'b1; sel = 1'b0; fresh = 1'b1;
        end else if (r1_req) begin
          grant = 1'b1; sel = 1'b1; fresh = 1'b1;
        end
      end
      OWN0: begin
        if (r0_req) begin
          grant = 1'b1; sel = 1'b0;
        end else if (r1_req) begin
          grant = 1'b1; sel = 1'b1; fresh = 1'b1;
        end
      end
      OWN1: begin
        if (r1_req) begin
          grant = 1'b1; sel = 1'b1;
        end else if (r0_req) begin
          grant = 1'b1; sel = 1'b0; fresh = 1'b1;
        end
      end
      default: ;
    endcase
    if (!rst_n) grant = 1'b0;

    // A fresh tenure (new owner this cycle) starts its burst count from zero.
    cnt_cur   = fresh ? '0 : burst_cnt_q;
    other_req = sel ? r0_req : r1_req;
    we_sel    = sel ? r1_we : r0_we;

    state_d     = IDLE;
    burst_cnt_d = burst_cnt_q;
    last_d      = last_q;
    if (grant) begin
      last_d = sel;
      if (other_req && cnt_cur == CNT_MAX) begin
        state_d     = sel ? OWN0 : OWN1;
        burst_cnt_d = '0;
      end else begin
        state_d     = sel ? OWN1 : OWN0;
        burst_cnt_d = (cnt_cur == CNT_MAX) ? CNT_MAX : cnt_cur + CW'(1);
      end
    end
    rd_pend_d = grant & ~we_sel;
  end

  assign r0_gnt    = grant & ~sel;
  assign r1_gnt    = grant &  sel;
  assign owner     = grant ? sel : owner_q;
  assign mem_we    = grant & we_sel;
  assign mem_addr  = grant ? (sel ? r1_addr : r0_addr) : mem_addr_q;
  assign mem_wdata = grant ? (sel ? r1_wdata : r0_wdata) : mem_wdata_q;

  assign r0_rvalid = rst_n & rd_pend_q & ~rd_tag_q;
  assign r1_rvalid = rst_n & rd_pend_q &  rd_tag_q;
  assign r0_rdata  = mem_rdata;
  assign r1_rdata  = mem_rdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      burst_cnt_q <= '0;
      last_q      <= 1'b1;
      owner_q     <= 1'b0;
      rd_pend_q   <= 1'b0;
      rd_tag_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      last_q      <= last_d;
      owner_q     <= owner;
      rd_pend_q   <= rd_pend_d;
      rd_tag_q    <= sel;
      mem_addr_q  <= mem_addr;
      mem_wdata_q <= mem_wdata;
    end
  end

`ifdef ARB_STATS_EN
  logic [15:0] beats0_q, beats1_q, wait0_q, wait1_q;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && v != 16'hFFFF) ? v + 16'd1 : v;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n || stat_clr) begin
      beats0_q <= '0;
      beats1_q <= '0;
      wait0_q  <= '0;
      wait1_q  <= '0;
    end else begin
      beats0_q <= sat_inc(beats0_q, r0_gnt);
      beats1_q <= sat_inc(beats1_q, r1_gnt);
      wait0_q  <= sat_inc(wait0_q, r0_req & ~r0_gnt);
      wait1_q  <= sat_inc(wait1_q, r1_req & ~r1_gnt);
    end
  end

  assign stat_beats0 = beats0_q;
  assign stat_beats1 = beats1_q;
  assign stat_wait0  = wait0_q;
  assign stat_wait1  = wait1_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 64K x 8 write-first RAM.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        r0_req, r0_we, r1_req, r1_we;
  logic [15:0] r0_addr, r1_addr;
  logic [7:0]  r0_wdata, r1_wdata;
  logic        r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
  logic [7:0]  r0_rdata, r1_rdata;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        owner;
`ifdef ARB_STATS_EN
  logic        stat_clr;
  logic [15:0] stat_beats0, stat_beats1, stat_wait0, stat_wait1;
`endif

  int checks = 0;
  int failures = 0;

  logic [7:0] ram [0:65535];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= mem_we ? mem_wdata : ram[mem_addr];
  end

  mem_port_arbiter #(.AW(16), .DW(8), .MAX_BURST(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
`ifdef ARB_STATS_EN
    .stat_clr(stat_clr), .stat_beats0(stat_beats0), .stat_beats1(stat_beats1),
    .stat_wait0(stat_wait0), .stat_wait1(stat_wait1),
`endif
    .owner(owner)
  );

  // Inputs change at the falling edge; outputs are sampled 1 ns later.
  task automatic do_reset();
    rst_n = 1'b0; r0_req = 1'b0; r1_req = 1'b0; r0_we = 1'b0; r1_we = 1'b0;
`ifdef ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; r0_req = 1'b1; r1_req = 1'b1; r0_we = 1'b1; r1_we = 1'b1;
    r0_addr = 16'h1234; r1_addr = 16'h5678; r0_wdata = 8'h00; r1_wdata = 8'h00;
`ifdef ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if ((r0_gnt | r1_gnt) !== 1'b0) begin failures++; $display("FAIL reset_gnt cyc=%0d got=%b%b exp=00", i, r0_gnt, r1_gnt); end
      checks++; if ((r0_rvalid | r1_rvalid) !== 1'b0) begin failures++; $display("FAIL reset_rvalid cyc=%0d got=%b%b exp=00", i, r0_rvalid, r1_rvalid); end
      checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we cyc=%0d got=%b exp=0", i, mem_we); end
      checks++; if (owner !== 1'b0) begin failures++; $display("FAIL reset_owner cyc=%0d got=%b exp=0", i, owner); end
      @(negedge clk);
    end
    #1;
    checks++; if (mem_addr !== 16'h0000) begin failures++; $display("FAIL reset_mem_addr got=%h exp=0000", mem_addr); end
    r0_req = 1'b0; r1_req = 1'b0; r0_we = 1'b0; r1_we = 1'b0; rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_solo_host();
    do_reset();
    r0_req = 1'b1; r0_we = 1'b1; r0_addr = 16'h0100; r0_wdata = 8'hA5;
    #1;
    checks++; if (r0_gnt !== 1'b1) begin failures++; $display("FAIL solo_wr_gnt got=%b exp=1", r0_gnt); end
    checks++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 16'h0100, 8'hA5}) begin failures++; $display("FAIL solo_wr_mem got=%b/%h/%h exp=1/0100/a5", mem_we, mem_addr, mem_wdata); end
    @(negedge clk);
    r0_we = 1'b0; r0_wdata = 8'h00;
    #1;
    checks++; if (r0_gnt !== 1'b1) begin failures++; $display("FAIL solo_rd_gnt got=%b exp=1", r0_gnt); end
    checks++; if (mem_we !== 1'b0 || r0_rvalid !== 1'b0) begin failures++; $display("FAIL solo_rd_issue got=we%b rv%b exp=we0 rv0", mem_we, r0_rvalid); end
    @(negedge clk);
    r0_req = 1'b0;
    #1;
    checks++; if (r0_rvalid !== 1'b1 || r0_rdata !== 8'hA5) begin failures++; $display("FAIL solo_rdata got=%b/%h exp=1/a5", r0_rvalid, r0_rdata); end
    checks++; if (r1_rvalid !== 1'b0) begin failures++; $display("FAIL solo_r1_rvalid got=%b exp=0", r1_rvalid); end
    checks++; if (mem_we !== 1'b0 || mem_addr !== 16'h0100) begin failures++; $display("FAIL solo_idle_hold got=%b/%h exp=0/0100", mem_we, mem_addr); end
    @(negedge clk);
  endtask

  task automatic test_contention();
    logic exp0, prev0;
    do_reset();
    r0_req = 1'b1; r1_req = 1'b1; r0_we = 1'b0; r1_we = 1'b0;
    r0_addr = 16'h0020; r1_addr = 16'h8000;
    prev0 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      exp0 = ((i / 16) % 2) == 0;
      #1;
      checks++; if (r0_gnt !== exp0 || r1_gnt !== ~exp0) begin failures++; $display("FAIL contention_gnt cyc=%0d got=%b%b exp=%b%b", i, r0_gnt, r1_gnt, exp0, ~exp0); end
      if (i > 0) begin
        checks++; if (r0_rvalid !== prev0 || r1_rvalid !== ~prev0) begin failures++; $display("FAIL contention_rvalid cyc=%0d got=%b%b exp=%b%b", i, r0_rvalid, r1_rvalid, prev0, ~prev0); end
      end
      prev0 = exp0;
      @(negedge clk);
    end
    r0_req = 1'b0; r1_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_early_release();
    do_reset();
    r1_req = 1'b1; r1_addr = 16'h4000; r0_addr = 16'h0030;
    #1;
    checks++; if (r1_gnt !== 1'b1) begin failures++; $display("FAIL early_cu_first got=%b exp=1", r1_gnt); end
    @(negedge clk);
    r0_req = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (r0_gnt !== 1'b0 || r1_gnt !== 1'b1) begin failures++; $display("FAIL early_cu_owns got=%b%b exp=01", r0_gnt, r1_gnt); end
    @(negedge clk);
    r1_req = 1'b0;
    #1;
    checks++; if (r0_gnt !== 1'b1 || r1_gnt !== 1'b0) begin failures++; $display("FAIL early_handover got=%b%b exp=10", r0_gnt, r1_gnt); end
    checks++; if (owner !== 1'b0) begin failures++; $display("FAIL early_owner got=%b exp=0", owner); end
    @(negedge clk);
    r0_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_tag_switch();
    do_reset();
    r0_req = 1'b1; r1_req = 1'b1; r0_addr = 16'h0010; r1_addr = 16'h4000;
    for (int i = 0; i < 18; i++) begin
      #1;
      if (i == 15) begin
        checks++; if (r0_gnt !== 1'b1) begin failures++; $display("FAIL tag_last_host_beat got=%b exp=1", r0_gnt); end
      end
      if (i == 16) begin
        checks++; if (r1_gnt !== 1'b1) begin failures++; $display("FAIL tag_cu_gnt got=%b exp=1", r1_gnt); end
        checks++; if (r0_rvalid !== 1'b1 || r0_rdata !== 8'h11 || r1_rvalid !== 1'b0) begin failures++; $display("FAIL tag_host_ret got=%b/%h r1v=%b exp=1/11 r1v=0", r0_rvalid, r0_rdata, r1_rvalid); end
      end
      if (i == 17) begin
        checks++; if (r1_rvalid !== 1'b1 || r1_rdata !== 8'h22 || r0_rvalid !== 1'b0) begin failures++; $display("FAIL tag_cu_ret got=%b/%h r0v=%b exp=1/22 r0v=0", r1_rvalid, r1_rdata, r0_rvalid); end
      end
      @(negedge clk);
    end
    r0_req = 1'b0; r1_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = 16'h4000;
    @(negedge clk); @(negedge clk); @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (r1_rvalid !== 1'b0 || r1_gnt !== 1'b0) begin failures++; $display("FAIL midrst_during got=rv%b g%b exp=rv0 g0", r1_rvalid, r1_gnt); end
    @(negedge clk);
    rst_n = 1'b1; r1_req = 1'b0;
    #1;
    checks++; if (r1_rvalid !== 1'b0 || r0_rvalid !== 1'b0) begin failures++; $display("FAIL midrst_discard got=%b%b exp=00", r0_rvalid, r1_rvalid); end
    checks++; if (owner !== 1'b0) begin failures++; $display("FAIL midrst_owner got=%b exp=0", owner); end
`ifdef ARB_STATS_EN
    checks++; if (stat_beats1 !== 16'd0 || stat_wait1 !== 16'd0) begin failures++; $display("FAIL midrst_stats got=%0d/%0d exp=0/0", stat_beats1, stat_wait1); end
    @(negedge clk);
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 16'h0040;
    @(negedge clk);
    r1_req = 1'b1;
    #1;
    checks++; if (stat_beats0 !== 16'd1) begin failures++; $display("FAIL stats_beats0 got=%0d exp=1", stat_beats0); end
    @(negedge clk);
    stat_clr = 1'b1;
    #1;
    checks++; if (stat_wait1 !== 16'd1 || r0_gnt !== 1'b1) begin failures++; $display("FAIL stats_wait1 got=%0d g%b exp=1 g1", stat_wait1, r0_gnt); end
    @(negedge clk);
    stat_clr = 1'b0; r0_req = 1'b0; r1_req = 1'b0;
    #1;
    checks++; if (stat_beats0 !== 16'd0 || stat_wait1 !== 16'd0) begin failures++; $display("FAIL stats_clr_wins got=%0d/%0d exp=0/0", stat_beats0, stat_wait1); end
`endif
    @(negedge clk);
  endtask

  initial begin
    ram[16'h0010] = 8'h11;
    ram[16'h4000] = 8'h22;
    test_reset();
    test_solo_host();
    test_contention();
    test_early_release();
    test_tag_switch();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
